eio_test_responder: RTL and testbench
=====================================

EIO_TEST_RESPONDER -- requirements
Module: eio_test_responder

Interface
REQ-001 Parameter: A_SZ, 32, address width.
REQ-002 Parameter: D_SZ, 32, data width.
REQ-003 Parameter: NUM_REGS, 4, number of read/write scratch registers (1..64).
REQ-004 Parameter: LATENCY, 2, wait cycles inserted before ack (0..15).
REQ-005 Parameter: BASE_ADDR, 32'h8000_0000, byte address of scratch register 0.
REQ-006 Parameter: TIMEOUT, 100000, cycle count at which the test is forced to done/fail.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk_in  input  1  clock, all state updates on rising edge.
REQ-009 reset_in  input  1  synchronous active-high reset.
REQ-010 req_in  input  1  I/O request, held high until ack_out.
REQ-011 rd_wr_in  input  1  1 = read, 0 = write.
REQ-012 addr_in  input  A_SZ  byte address.
REQ-013 wr_data_in  input  D_SZ  write data.
REQ-014 ack_out  output  1  one-cycle completion pulse.
REQ-015 ack_fault_out  output  1  qualifies ack_out: access faulted.
REQ-016 ack_data_out  output  D_SZ  read data, valid with ack_out.
REQ-017 busy_out  output  1  request accepted, not yet acked.
REQ-018 done_out  output  1  sticky: test completed or timed out.
REQ-019 pass_out  output  1  sticky: valid when done_out, 1 = pass.
REQ-020 status_out  output  D_SZ  last value written to mailbox.

Function
REQ-021 Register map (word index = (addr_in - BASE_ADDR) >> 2): 0..NUM_REGS-1 scratch RW; NUM_REGS mailbox RW; NUM_REGS+1 cycle counter RO.
REQ-022 Fault conditions: addr_in[1:0] != 0, addr_in < BASE_ADDR, index > NUM_REGS+1, or write to cycle counter.
REQ-023 Faulted access: no state change; ack_fault_out=1, ack_data_out=32'hdeadbeef (zero-extended/truncated to D_SZ).
REQ-024 FSM states IDLE, WAIT, ACK; reset state IDLE.
REQ-025 IDLE: req_in=1 -> capture rd_wr_in, addr_in, wr_data_in, load latency counter with LATENCY; go WAIT if LATENCY>0, else ACK.
REQ-026 WAIT: decrement counter; at counter==1 go ACK; req_in ignored.
REQ-027 ACK: ack_out=1 for exactly this cycle; write side-effects commit on this edge; next state IDLE.
REQ-028 Acceptance at edge k -> ack_out high in cycle k+1+LATENCY; inputs sampled only at acceptance.
REQ-029 req_in still high in the cycle after ACK is a new request (back-to-back); minimum spacing between acks is LATENCY+2 cycles.
REQ-030 busy_out=1 in WAIT and ACK, 0 in IDLE.
REQ-031 Cycle counter: free-running, +1 every cycle after reset, saturates at all-ones; read returns value at ACK cycle.
REQ-032 Mailbox write with nonzero data: status_out<=data, done_out<=1, pass_out<=(data==1); first write wins, later writes update only the register value.
REQ-033 Mailbox write of zero: updates register only, done unaffected.
REQ-034 Cycle counter == TIMEOUT with done_out=0: done_out<=1, pass_out<=0, status_out unchanged.
REQ-035 Mailbox write and timeout on same edge: mailbox write takes priority.
REQ-036 ack_out, ack_fault_out, ack_data_out are registered; ack_fault_out and ack_data_out are 0 whenever ack_out=0.

Reset
REQ-037 reset_in=1: FSM->IDLE, all outputs 0, scratch, mailbox, cycle counter, latency counter cleared.
REQ-038 reset_in asserted in WAIT or ACK: pending request dropped, no ack_out, no write commit.
REQ-039 First request accepted on the first edge with reset_in=0 and req_in=1.

Verification
REQ-040 LATENCY=2: write 32'h1234_5678 to BASE_ADDR at edge k -> ack_out in cycle k+3, fault 0; read back -> ack_data_out=32'h1234_5678.
REQ-041 Read BASE_ADDR+2 (misaligned) and write to cycle-counter index -> ack_out with ack_fault_out=1, ack_data_out=32'hdeadbeef, scratch unchanged.
REQ-042 Write 1 to mailbox -> done_out=1, pass_out=1, status_out=1; subsequent write 0 -> done_out/pass_out stay 1.
REQ-043 TIMEOUT=20, no requests -> done_out=1, pass_out=0 after cycle counter reaches 20.
REQ-044 req_in held high continuously, LATENCY=0 -> ack_out every 2nd cycle, busy_out toggling.
REQ-045 reset_in pulsed during WAIT of a write -> no ack_out, target register reads 0 after reset.

Source files
------------

// File: rtl/eio_test_responder.sv
// Test-harness I/O responder: scratch registers, a pass/fail mailbox
// and a free-running cycle counter behind a fixed-latency req/ack port.
`timescale 1ns/1ps
module eio_test_responder #(
    parameter int              A_SZ      = 32,
    parameter int              D_SZ      = 32,
    parameter int              NUM_REGS  = 4,
    parameter int              LATENCY   = 2,
    parameter logic [A_SZ-1:0] BASE_ADDR = A_SZ'(32'h8000_0000),
    parameter int              TIMEOUT   = 100000
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            req_in,
    input  logic            rd_wr_in,
    input  logic [A_SZ-1:0] addr_in,
    input  logic [D_SZ-1:0] wr_data_in,
    output logic            ack_out,
    output logic            ack_fault_out,
    output logic [D_SZ-1:0] ack_data_out,
    output logic            busy_out,
    output logic            done_out,
    output logic            pass_out,
    output logic [D_SZ-1:0] status_out
);

    localparam logic [D_SZ-1:0] BAD_DATA = D_SZ'(32'hdeadbeef);
    localparam logic [A_SZ-1:0] MBOX_IDX = A_SZ'(NUM_REGS);
    localparam logic [A_SZ-1:0] CNTR_IDX = A_SZ'(NUM_REGS + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [3:0]      lat_q, lat_d;
    logic            rd_q, rd_d;
    logic [A_SZ-1:0] addr_q, addr_d;
    logic [D_SZ-1:0] wd_q, wd_d;
    logic            ack_q, ack_d;
    logic            fault_q, fault_d;
    logic [D_SZ-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [D_SZ-1:0] status_q, status_d;
    logic [D_SZ-1:0] mbox_q, mbox_d;
    logic [D_SZ-1:0] cnt_q, cnt_d;
    logic [D_SZ-1:0] regs_q [NUM_REGS];
    logic [D_SZ-1:0] regs_d [NUM_REGS];

    logic            cur_rd;
    logic [A_SZ-1:0] cur_addr;
    logic [A_SZ-1:0] idx;
    logic            cur_fault;
    logic [D_SZ-1:0] rd_val;
    logic            wr_en;

    // Decode from live inputs at acceptance (zero-latency path), else captured.
    always_comb begin
        cur_rd    = (state_q == S_IDLE) ? rd_wr_in : rd_q;
        cur_addr  = (state_q == S_IDLE) ? addr_in : addr_q;
        idx       = (cur_addr - BASE_ADDR) >> 2;
        cur_fault = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE_ADDR) ||
                    (idx > CNTR_IDX) || (!cur_rd && idx == CNTR_IDX);
        rd_val    = '0;
        if (idx == MBOX_IDX) begin
            rd_val = mbox_q;
        end else if (idx == CNTR_IDX) begin
            rd_val = cnt_d;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == A_SZ'(i)) rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        done_d   = done_q;
        pass_d   = pass_q;
        status_d = status_q;
        mbox_d   = mbox_q;
        regs_d   = regs_q;
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        wr_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_in) begin
                    rd_d    = rd_wr_in;
                    addr_d  = addr_in;
                    wd_d    = wr_data_in;
                    lat_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
                wr_en   = !rd_q && !cur_fault;
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            if (idx == MBOX_IDX) begin
                mbox_d = wd_q;
                if (wd_q != '0 && !done_q) begin
                    done_d   = 1'b1;
                    pass_d   = (wd_q == D_SZ'(1));
                    status_d = wd_q;
                end
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx == A_SZ'(i)) regs_d[i] = wd_q;
                end
            end
        end

        // A same-edge mailbox verdict already set done_d and wins.
        if (cnt_q == D_SZ'(TIMEOUT) && !done_d) begin
            done_d = 1'b1;
            pass_d = 1'b0;
        end

        ack_d   = (state_d == S_ACK);
        fault_d = ack_d && cur_fault;
        data_d  = '0;
        if (ack_d) data_d = cur_fault ? BAD_DATA : (cur_rd ? rd_val : '0);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            ack_q    <= 1'b0;
            fault_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            status_q <= '0;
            mbox_q   <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            ack_q    <= ack_d;
            fault_q  <= fault_d;
            data_q   <= data_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            status_q <= status_d;
            mbox_q   <= mbox_d;
            cnt_q    <= cnt_d;
            regs_q   <= regs_d;
        end
    end

    assign ack_out       = ack_q;
    assign ack_fault_out = fault_q;
    assign ack_data_out  = data_q;
    assign busy_out      = (state_q != S_IDLE);
    assign done_out      = done_q;
    assign pass_out      = pass_q;
    assign status_out    = status_q;

endmodule

// File: tb/tb_eio_test_responder.sv
// Directed bench for eio_test_responder: a LATENCY=2 instance plus a
// LATENCY=0 / TIMEOUT=20 instance for timeout and back-to-back cases.
`timescale 1ns/1ps
module tb_eio_test_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req2 = 1'b0;
    logic        rdwr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        ack, af, busy, done, pass;
    logic [31:0] ad, status;
    logic        ack2, af2, busy2, done2, pass2;
    logic [31:0] ad2, status2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    eio_test_responder #(.LATENCY(2)) dut (
        .clk_in(clk), .reset_in(rst), .req_in(req), .rd_wr_in(rdwr),
        .addr_in(addr), .wr_data_in(wdata),
        .ack_out(ack), .ack_fault_out(af), .ack_data_out(ad),
        .busy_out(busy), .done_out(done), .pass_out(pass),
        .status_out(status)
    );

    eio_test_responder #(.LATENCY(0), .TIMEOUT(20)) dut2 (
        .clk_in(clk), .reset_in(rst), .req_in(req2), .rd_wr_in(rdwr),
        .addr_in(addr), .wr_data_in(wdata),
        .ack_out(ack2), .ack_fault_out(af2), .ack_data_out(ad2),
        .busy_out(busy2), .done_out(done2), .pass_out(pass2),
        .status_out(status2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds req until ack (bounded), then returns to IDLE.
    task automatic xact(input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output logic f, output int n);
        rdwr = rd;
        addr = a;
        wdata = d;
        req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < 16);
        req = 1'b0;
        rdata = ad;
        f = af;
        tick();
    endtask

    initial begin
        logic [31:0] d, d1;
        logic        f;
        int          n;
        logic        seen;

        repeat (3) tick();
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_fault", {31'd0, af}, 0);
        chk("rst_data", ad, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_status", status, 0);

        rst = 1'b0;
        repeat (20) tick();
        chk("to_before", {31'd0, done2}, 0);
        tick();
        chk("to_done", {31'd0, done2}, 1);
        chk("to_pass", {31'd0, pass2}, 0);
        chk("to_status", status2, 0);

        xact(1'b0, BASE, 32'h1234_5678, d, f, n);
        chk("wr_latency", n, 3);
        chk("wr_fault", {31'd0, f}, 0);
        chk("ack_pulse", {31'd0, ack}, 0);
        xact(1'b1, BASE, 32'h0, d, f, n);
        chk("rd_data", d, 32'h1234_5678);
        chk("rd_fault", {31'd0, f}, 0);

        xact(1'b1, BASE + 32'd2, 32'h0, d, f, n);
        chk("mis_fault", {31'd0, f}, 1);
        chk("mis_data", d, 32'hdead_beef);
        xact(1'b0, BASE + 32'd20, 32'h5555_5555, d, f, n);
        chk("cwr_fault", {31'd0, f}, 1);
        chk("cwr_data", d, 32'hdead_beef);
        xact(1'b1, BASE + 32'd24, 32'h0, d, f, n);
        chk("oob_fault", {31'd0, f}, 1);
        xact(1'b1, 32'h7fff_fffc, 32'h0, d, f, n);
        chk("low_fault", {31'd0, f}, 1);
        xact(1'b1, BASE, 32'h0, d, f, n);
        chk("scr_kept", d, 32'h1234_5678);

        xact(1'b1, BASE + 32'd20, 32'h0, d1, f, n);
        xact(1'b1, BASE + 32'd20, 32'h0, d, f, n);
        chk("cnt_delta", d - d1, 4);

        chk("mb_pre_done", {31'd0, done}, 0);
        xact(1'b0, BASE + 32'd16, 32'd1, d, f, n);
        chk("mb_done", {31'd0, done}, 1);
        chk("mb_pass", {31'd0, pass}, 1);
        chk("mb_status", status, 1);
        xact(1'b0, BASE + 32'd16, 32'd0, d, f, n);
        chk("mb0_done", {31'd0, done}, 1);
        chk("mb0_pass", {31'd0, pass}, 1);
        xact(1'b1, BASE + 32'd16, 32'h0, d, f, n);
        chk("mb_reg", d, 0);
        xact(1'b0, BASE + 32'd16, 32'd2, d, f, n);
        chk("mb2_status", status, 1);
        chk("mb2_pass", {31'd0, pass}, 1);

        rdwr = 1'b0;
        addr = BASE + 32'd4;
        wdata = 32'haaaa_aaaa;
        req = 1'b1;
        tick();
        chk("wait_busy", {31'd0, busy}, 1);
        req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_busy", {31'd0, busy}, 0);
        chk("rstw_done", {31'd0, done}, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | ack;
        end
        chk("rstw_noack", {31'd0, seen}, 0);
        xact(1'b1, BASE + 32'd4, 32'h0, d, f, n);
        chk("rstw_reg", d, 0);
        xact(1'b1, BASE, 32'h0, d, f, n);
        chk("rst_scratch", d, 0);

        rdwr = 1'b1;
        addr = BASE;
        req2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_ack", {31'd0, ack2}, (i % 2 == 0) ? 1 : 0);
            chk("b2b_busy", {31'd0, busy2}, (i % 2 == 0) ? 1 : 0);
            chk("b2b_fault", {31'd0, af2}, 0);
        end
        req2 = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
